conversor_bcd: RTL and testbench
================================

CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 SHALL provide parameter LARGURA, default 8: width of the binary input in bits (valid range 4..16).
REQ-002 SHALL provide parameter DIGITOS, default 3: number of BCD digits produced; 10^DIGITOS SHALL exceed 2^LARGURA-1.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset; sampled on the rising clock edge only.
REQ-005 SHALL have port inicio, input, 1: start request, sampled each rising edge.
REQ-006 SHALL have port entrada, input, LARGURA: unsigned binary value, captured when a start is accepted.
REQ-007 SHALL have port ocupado, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port pronto, output, 1: one-cycle pulse marking a new valid result on saida.
REQ-009 SHALL have port saida, output, 4*DIGITOS: packed BCD result; bits [3:0] are units, [7:4] tens, [11:8] hundreds, and so on; each nibble feeds one 7-segment decoder.

Function
REQ-010 SHALL implement a two-state FSM: OCIOSO (idle) and CONVERTE (shift-add-3 iteration).
REQ-011 In OCIOSO with inicio=1, SHALL capture entrada into an internal binary shift register, clear the internal BCD scratch register, load the iteration counter with LARGURA, and go to CONVERTE.
REQ-012 In OCIOSO with inicio=0, SHALL hold all state and outputs.
REQ-013 In CONVERTE, SHALL perform exactly one double-dabble step per cycle: every scratch nibble >= 5 gets +3 (4-bit result), then scratch and binary register shift left one bit together, with the binary MSB entering scratch bit 0.
REQ-014 SHALL decrement the counter once per CONVERTE cycle; the cycle performing the LARGURA-th shift SHALL load saida with the final scratch value, set pronto=1 for the next cycle, and return to OCIOSO.
REQ-015 Latency: with inicio sampled at edge N, pronto=1 and saida valid during the cycle after edge N+LARGURA (LARGURA+1 cycles after acceptance; 9 for defaults).
REQ-016 ocupado SHALL equal 1 exactly while the FSM is in CONVERTE; pronto and ocupado SHALL never both be 1.
REQ-017 inicio while ocupado=1 SHALL be ignored; no queuing; the running conversion SHALL be unaffected.
REQ-018 Changes on entrada after acceptance SHALL NOT affect the running conversion.
REQ-019 inicio=1 in the pronto cycle SHALL be accepted (FSM is in OCIOSO), giving back-to-back conversions every LARGURA+1 cycles.
REQ-020 saida SHALL hold the last completed result until the next completion; it SHALL NOT show intermediate scratch values.
REQ-021 Every saida nibble SHALL be in 0..9 for any input satisfying REQ-002.
REQ-022 pronto SHALL be a registered output, high for exactly one cycle per completed conversion.

Reset
REQ-023 With reset=0 at a rising edge, SHALL set FSM to OCIOSO, saida=0, pronto=0, ocupado=0, and clear counter, binary and scratch registers.
REQ-024 Reset mid-conversion SHALL abort it with no pronto pulse; saida SHALL read 0 afterwards.
REQ-025 inicio asserted together with reset=0 SHALL be ignored; the first start is accepted on the first edge with reset=1.

Verification
REQ-026 Defaults, reset released, inicio pulse with entrada=8'd255 -> ocupado high 8 cycles, then pronto=1 one cycle with saida=12'h255.
REQ-027 entrada=0 -> saida=12'h000, pronto after 9 cycles; entrada=8'd99 -> saida=12'h099; entrada=8'd100 -> saida=12'h100.
REQ-028 inicio with entrada=8'd37, then inicio again with entrada=8'd200 at cycle 3 while ocupado=1 -> second request ignored, single pronto with saida=12'h037.
REQ-029 entrada=8'd128 converting, inicio held high with entrada=8'd42 in the pronto cycle -> first result 12'h128, second pronto exactly 9 cycles later with 12'h042.
REQ-030 Start entrada=8'd255 after a prior result 12'h099, reset=0 at cycle 4 -> no pronto, ocupado=0, saida=12'h000; next start with entrada=8'd7 -> saida=12'h007.
REQ-031 Exhaustive sweep 0..255 with random inicio gaps -> each saida matches the decimal digits of entrada; one pronto per accepted start.

Source files
------------

// File: rtl/conversor_bcd_if.sv
// Handshake bundle for the binary-to-BCD converter: start request, operand,
// busy flag, completion pulse and packed BCD result.
interface conversor_bcd_if #(
   parameter int LARGURA = 8,
   parameter int DIGITOS = 3
);
   logic                   inicio;
   logic [LARGURA-1:0]     entrada;
   logic                   ocupado;
   logic                   pronto;
   logic [4*DIGITOS-1:0]   saida;

   modport master (
      output inicio,
      output entrada,
      input  ocupado,
      input  pronto,
      input  saida
   );

   modport slave (
      input  inicio,
      input  entrada,
      output ocupado,
      output pronto,
      output saida
   );
endinterface

// File: rtl/conversor_bcd.sv
// Sequential double-dabble converter: one shift-add-3 step per clock,
// result published on saida with a one-cycle pronto pulse.
module conversor_bcd #(
   parameter int LARGURA = 8,
   parameter int DIGITOS = 3
) (
   input  logic            clock,
   input  logic            reset,
   conversor_bcd_if.slave  bus
);
   localparam int CW = $clog2(LARGURA + 1);
   localparam int BW = 4 * DIGITOS;

   typedef enum logic {OCIOSO, CONVERTE} estado_t;

   estado_t            estado_reg, estado_next;
   logic [CW-1:0]      contador_reg, contador_next;
   logic [LARGURA-1:0] binario_reg, binario_next;
   logic [BW-1:0]      scratch_reg, scratch_next;
   logic [BW-1:0]      saida_reg, saida_next;
   logic               pronto_reg, pronto_next;

   logic [BW-1:0]      ajustado;
   logic [BW-1:0]      deslocado;

   // Each digit is corrected before the shift so it carries cleanly into the next one
   genvar gi;
   generate
      for (gi = 0; gi < DIGITOS; gi++) begin : g_ajuste
         assign ajustado[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                      ? scratch_reg[4*gi +: 4] + 4'd3
                                      : scratch_reg[4*gi +: 4];
      end
   endgenerate

   assign deslocado = {ajustado[BW-2:0], binario_reg[LARGURA-1]};

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_reg   <= OCIOSO;
         contador_reg <= '0;
         binario_reg  <= '0;
         scratch_reg  <= '0;
         saida_reg    <= '0;
         pronto_reg   <= 1'b0;
      end else begin
         estado_reg   <= estado_next;
         contador_reg <= contador_next;
         binario_reg  <= binario_next;
         scratch_reg  <= scratch_next;
         saida_reg    <= saida_next;
         pronto_reg   <= pronto_next;
      end
   end

   always_comb begin
      estado_next   = estado_reg;
      contador_next = contador_reg;
      binario_next  = binario_reg;
      scratch_next  = scratch_reg;
      saida_next    = saida_reg;
      pronto_next   = 1'b0;

      case (estado_reg)
         OCIOSO: begin
            if (bus.inicio) begin
               binario_next  = bus.entrada;
               scratch_next  = '0;
               contador_next = CW'(LARGURA);
               estado_next   = CONVERTE;
            end
         end
         CONVERTE: begin
            scratch_next  = deslocado;
            binario_next  = {binario_reg[LARGURA-2:0], 1'b0};
            contador_next = contador_reg - CW'(1);
            // Last shift: publish the shifted value directly, scratch is never exposed
            if (contador_reg == CW'(1)) begin
               saida_next  = deslocado;
               pronto_next = 1'b1;
               estado_next = OCIOSO;
            end
         end
         default: estado_next = OCIOSO;
      endcase
   end

   assign bus.ocupado = (estado_reg == CONVERTE);
   assign bus.pronto  = pronto_reg;
   assign bus.saida   = saida_reg;
endmodule

// File: tb/tb_conversor_bcd.sv
// Directed bench for conversor_bcd: latency, overlap rejection, back-to-back
// starts, reset abort and a full 0..255 sweep with random gaps.
module tb_conversor_bcd;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   conversor_bcd_if #(.LARGURA(8), .DIGITOS(3)) bus ();

   conversor_bcd #(.LARGURA(8), .DIGITOS(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int passed = 0;
   int total = 0;
   int pronto_cnt = 0;
   int both_err = 0;

   always @(negedge clock) begin
      if (bus.pronto === 1'b1) pronto_cnt++;
      if (bus.pronto === 1'b1 && bus.ocupado === 1'b1) both_err++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [11:0] bcd(input int v);
      bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Waits for pronto; reports samples taken and how many showed ocupado
   task automatic wait_pronto(output int k, output int occ);
      k = 0;
      occ = 0;
      while (bus.pronto !== 1'b1 && k < 40) begin
         if (bus.ocupado === 1'b1) occ++;
         tick();
         k++;
      end
   endtask

   task automatic finish_checks(input string tag, input logic [11:0] exp, input int k, input int occ);
      check({tag, "_lat"}, 32'(k), 32'd8);
      check({tag, "_occ"}, 32'(occ), 32'd8);
      check({tag, "_saida"}, 32'(bus.saida), 32'(exp));
      check({tag, "_ocup_off"}, 32'(bus.ocupado), 32'd0);
      tick();
      check({tag, "_pulse"}, 32'(bus.pronto), 32'd0);
      check({tag, "_hold"}, 32'(bus.saida), 32'(exp));
   endtask

   task automatic run(input string tag, input logic [7:0] v, input logic [11:0] exp);
      int k, occ;
      bus.inicio  = 1'b1;
      bus.entrada = v;
      tick();
      bus.inicio  = 1'b0;
      bus.entrada = 8'($urandom);
      wait_pronto(k, occ);
      finish_checks(tag, exp, k, occ);
   endtask

   initial begin
      int k, occ, base;
      bus.inicio  = 1'b1;
      bus.entrada = 8'd5;

      // start held during reset must be ignored
      tick();
      tick();
      check("rst_ocupado", 32'(bus.ocupado), 32'd0);
      check("rst_pronto", 32'(bus.pronto), 32'd0);
      check("rst_saida", 32'(bus.saida), 32'd0);

      reset = 1'b1;
      tick();
      bus.inicio = 1'b0;
      check("first_accept", 32'(bus.ocupado), 32'd1);
      wait_pronto(k, occ);
      finish_checks("first5", 12'h005, k, occ);

      run("v255", 8'd255, 12'h255);
      run("v0", 8'd0, 12'h000);
      run("v99", 8'd99, 12'h099);
      run("v100", 8'd100, 12'h100);

      // second start while busy is dropped
      base = pronto_cnt;
      bus.inicio  = 1'b1;
      bus.entrada = 8'd37;
      tick();
      bus.inicio = 1'b0;
      tick();
      bus.inicio  = 1'b1;
      bus.entrada = 8'd200;
      tick();
      bus.inicio = 1'b0;
      wait_pronto(k, occ);
      check("ovl_lat", 32'(k), 32'd6);
      check("ovl_saida", 32'(bus.saida), 32'h037);
      repeat (12) tick();
      check("ovl_single", 32'(pronto_cnt - base), 32'd1);
      check("ovl_saida_hold", 32'(bus.saida), 32'h037);

      // back-to-back: start accepted in the pronto cycle
      bus.inicio  = 1'b1;
      bus.entrada = 8'd128;
      tick();
      bus.inicio = 1'b0;
      wait_pronto(k, occ);
      check("b2b_first", 32'(bus.saida), 32'h128);
      bus.inicio  = 1'b1;
      bus.entrada = 8'd42;
      tick();
      bus.inicio = 1'b0;
      check("b2b_accept", 32'(bus.ocupado), 32'd1);
      wait_pronto(k, occ);
      finish_checks("b2b_second", 12'h042, k, occ);

      // reset mid-conversion aborts without a pulse
      run("pre99", 8'd99, 12'h099);
      base = pronto_cnt;
      bus.inicio  = 1'b1;
      bus.entrada = 8'd255;
      tick();
      bus.inicio = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("abort_saida", 32'(bus.saida), 32'h000);
      check("abort_ocupado", 32'(bus.ocupado), 32'd0);
      repeat (12) tick();
      check("abort_no_pronto", 32'(pronto_cnt - base), 32'd0);
      run("after_abort", 8'd7, 12'h007);

      // full sweep with random idle gaps
      base = pronto_cnt;
      for (int v = 0; v < 256; v++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         repeat (gap) tick();
         run($sformatf("sweep%0d", v), 8'(v), bcd(v));
      end
      check("sweep_pulses", 32'(pronto_cnt - base), 32'd256);
      check("never_both", 32'(both_err), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
